mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
Multi-cycle sequencer for the 8-bit MIPS-subset datapath (imem, reg_file, ALU, dram).
Owns the PC and a Moore FSM, and drives reg_file addresses and valid_bits, ALU op, memory read and writeback select for every instruction.
At program end it halts by issuing one read of OUTPUT_REG and asserting done.
The datapath holds only storage and arithmetic; all sequencing lives here.

Parameters:
PC_W, 8, PC / imem address width; PC arithmetic wraps modulo 2^PC_W
MAX_PC, 11, halt when PC >= MAX_PC (unsigned) after writeback
OUTPUT_REG, 4, register number read in DUMP

Ports:
clk  in  1  clock, all state changes on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin execution from PC 0; honoured only in IDLE or DONE
inst  in  32  instruction word at imem_addr; sampled in FETCH
alu_eq  in  1  datapath read_value_1 == read_value_2; sampled in EXEC
rs_val  in  8  reg_file read value 1; sampled in EXEC (jr target)
imem_addr  out  PC_W  current PC
rf_rs  out  5  reg_file read address 1
rf_rt  out  5  reg_file read address 2
rf_wr  out  5  reg_file write address
rf_valid  out  3  {rd1_en, rd2_en, wr_en}, same encoding as reg_file valid_bits
alu_op  out  2  0 add, 1 sub, 2 signed slt
alu_src_imm  out  1  ALU operand B = imm
imm  out  8  inst[7:0]
mem_rd  out  1  dram read strobe
wb_sel  out  2  0 ALU, 1 dram, 2 link_pc
link_pc  out  PC_W  PC+1 of a jal
illegal  out  1  sticky: unsupported opcode/funct seen
busy  out  1  FSM not in IDLE or DONE
done  out  1  high in DONE

Behaviour:
- All outputs are registered.
- Reset (async, any state): state IDLE; PC 0; every output 0.
- States and transitions:
  - IDLE → FETCH on start.
  - FETCH → DECODE → READ → EXEC → MEM → WB.
  - WB → FETCH if PC < MAX_PC, else WB → DUMP.
  - DUMP → DONE.
  - DONE → FETCH on start, with PC cleared to 0.
- Every instruction takes exactly 6 cycles. Latency from start to the first FETCH is 1 cycle.
- FETCH: latch inst into the instruction register; rf_valid = 000.
- DECODE: drive rf_rs = inst[25:21], rf_rt = inst[20:16], imm = inst[7:0].
  - rf_wr = inst[15:11] for R-type.
  - rf_wr = inst[20:16] for addiu/lw.
  - rf_wr = 31 for jal.
- READ: rf_valid is 110 for R-type/beq/bne, 100 for addiu/lw, 000 for j/jal.
- EXEC: rf_valid = 000; PC update happens here.
  - addu (funct 100001): alu_op 0, PC+1.
  - subu (100011): alu_op 1, PC+1.
  - slt (101010): alu_op 2, PC+1.
  - jr (001000): PC = rs_val[PC_W-1:0].
  - addiu (001001) and lw (100011): alu_op 0, alu_src_imm 1, PC+1.
  - beq (000100): PC = PC + sign_ext(imm) if alu_eq, else PC+1.
  - bne (000101): PC = PC + sign_ext(imm) if !alu_eq, else PC+1.
  - Branch offsets are relative to the branch's own PC, not PC+1.
  - j (000010): PC = inst[PC_W-1:0].
  - jal (000011): link_pc = PC+1, then PC = inst[PC_W-1:0].
  - Any other opcode or funct: illegal = 1; the instruction is a no-op; PC+1.
- MEM: mem_rd = 1 for lw only, for one cycle.
- WB:
  - rf_valid = 001 only for addu/subu/slt/addiu/lw/jal and only when rf_wr != 0; writes to $0 are suppressed.
  - Otherwise rf_valid = 000.
  - wb_sel is 1 for lw, 2 for jal, 0 otherwise.
- DUMP: rf_rs = OUTPUT_REG, rf_valid = 100 for exactly one cycle. The datapath samples out1 in the DONE cycle.
- DONE: done = 1 and busy = 0. Both hold until start.
- PC wrap: 8'hFF + 1 = 8'h00, with no flag. A branch or jump to PC >= MAX_PC halts after the current WB.
- illegal is cleared only by reset; start does not clear it.

Test Plan:
- Reset mid-EXEC (rst_n low asynchronously) → all outputs 0 immediately; state IDLE; PC 0. start afterwards → imem_addr 0 in FETCH.
- addiu $4,$0,0 at PC 0 (inst 0x24040000) → READ rf_valid=100, rf_rs=0; WB rf_valid=001, rf_wr=4, wb_sel=0; imem_addr=1 six cycles after FETCH.
- lw $1,0($0) (0x8C010000) → alu_src_imm=1; mem_rd=1 only in MEM; WB wb_sel=1, rf_wr=1.
- bne $6,$0,-3 (0x14C0FFFD) at PC 10 with alu_eq=0 → PC 7.
- beq (0x10C00005) at PC 6 with alu_eq=1 → PC 11 → DUMP with rf_rs=4, rf_valid=100 → done=1 next cycle, busy=0.
- jal 0x20 at PC 3 → link_pc=4; rf_wr=31; WB wb_sel=2, rf_valid=001; PC 0x20 → halt.
- addiu $0,$1,5 → WB rf_valid=000.
- Opcode 0x3F → illegal=1, PC+1, no write; illegal stays 1 after a later start.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multi-cycle sequencer for the 8-bit MIPS-subset datapath: owns the PC and the
// FETCH..WB state machine, and drives register-file, ALU, memory and writeback controls.
module mc_control_unit #(
  parameter int PC_W       = 8,
  parameter int MAX_PC     = 11,
  parameter int OUTPUT_REG = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     inst,
  input  logic            alu_eq,
  input  logic [7:0]      rs_val,
  output logic [PC_W-1:0] imem_addr,
  output logic [4:0]      rf_rs,
  output logic [4:0]      rf_rt,
  output logic [4:0]      rf_wr,
  output logic [2:0]      rf_valid,
  output logic [1:0]      alu_op,
  output logic            alu_src_imm,
  output logic [7:0]      imm,
  output logic            mem_rd,
  output logic [1:0]      wb_sel,
  output logic [PC_W-1:0] link_pc,
  output logic            illegal,
  output logic            busy,
  output logic            done
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_MEM, S_WB, S_DUMP, S_DONE
  } state_t;

  localparam logic [3:0] K_ADDU  = 4'd0;
  localparam logic [3:0] K_SUBU  = 4'd1;
  localparam logic [3:0] K_SLT   = 4'd2;
  localparam logic [3:0] K_JR    = 4'd3;
  localparam logic [3:0] K_ADDIU = 4'd4;
  localparam logic [3:0] K_LW    = 4'd5;
  localparam logic [3:0] K_BEQ   = 4'd6;
  localparam logic [3:0] K_BNE   = 4'd7;
  localparam logic [3:0] K_J     = 4'd8;
  localparam logic [3:0] K_JAL   = 4'd9;
  localparam logic [3:0] K_ILL   = 4'd10;

  localparam logic [PC_W-1:0] MAX_PC_L   = PC_W'(MAX_PC);
  localparam logic [4:0]      OUT_REG_L  = 5'(OUTPUT_REG);

  function automatic logic [3:0] decode_kind(input logic [31:0] w);
    logic [3:0] k;
    k = K_ILL;
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h21:   k = K_ADDU;
          6'h23:   k = K_SUBU;
          6'h2A:   k = K_SLT;
          6'h08:   k = K_JR;
          default: k = K_ILL;
        endcase
      end
      6'h09:   k = K_ADDIU;
      6'h23:   k = K_LW;
      6'h04:   k = K_BEQ;
      6'h05:   k = K_BNE;
      6'h02:   k = K_J;
      6'h03:   k = K_JAL;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic logic [4:0] wr_addr(input logic [31:0] w, input logic [3:0] k);
    logic [4:0] a;
    case (k)
      K_ADDU, K_SUBU, K_SLT: a = w[15:11];
      K_ADDIU, K_LW:         a = w[20:16];
      K_JAL:                 a = 5'd31;
      default:               a = 5'd0;
    endcase
    return a;
  endfunction

  function automatic logic [2:0] read_bits(input logic [3:0] k);
    logic [2:0] v;
    case (k)
      K_ADDU, K_SUBU, K_SLT, K_JR, K_BEQ, K_BNE: v = 3'b110;
      K_ADDIU, K_LW:                             v = 3'b100;
      default:                                   v = 3'b000;
    endcase
    return v;
  endfunction

  function automatic logic is_writer(input logic [3:0] k);
    logic r;
    case (k)
      K_ADDU, K_SUBU, K_SLT, K_ADDIU, K_LW, K_JAL: r = 1'b1;
      default:                                    r = 1'b0;
    endcase
    return r;
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_ir;
  logic [PC_W-1:0] r_pc;
  logic [4:0]      r_rf_rs, r_rf_rt, r_rf_wr;
  logic [2:0]      r_rf_valid;
  logic [1:0]      r_alu_op, r_wb_sel;
  logic            r_alu_src_imm, r_mem_rd, r_illegal, r_busy, r_done;
  logic [7:0]      r_imm;
  logic [PC_W-1:0] r_link_pc;

  logic [3:0]      w_kind;
  logic [3:0]      w_kind_in;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_off;
  logic [PC_W-1:0] w_pc_exec;
  logic            w_halt;
  logic            w_unused;

  assign w_kind    = decode_kind(r_ir);
  assign w_kind_in = decode_kind(inst);
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_off     = PC_W'($signed(r_ir[7:0]));
  assign w_halt    = (r_pc >= MAX_PC_L);
  assign w_unused  = ^r_ir;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH; else w_next = S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = S_READ;
      S_READ:   w_next = S_EXEC;
      S_EXEC:   w_next = S_MEM;
      S_MEM:    w_next = S_WB;
      S_WB:     if (w_halt) w_next = S_DUMP; else w_next = S_FETCH;
      S_DUMP:   w_next = S_DONE;
      S_DONE:   if (start) w_next = S_FETCH; else w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  // PC target resolved in EXEC; branch offsets are relative to the branch itself
  always_comb begin
    w_pc_exec = w_pc_inc;
    case (w_kind)
      K_JR:         w_pc_exec = PC_W'(rs_val);
      K_BEQ:        if (alu_eq)  w_pc_exec = r_pc + w_off; else w_pc_exec = w_pc_inc;
      K_BNE:        if (!alu_eq) w_pc_exec = r_pc + w_off; else w_pc_exec = w_pc_inc;
      K_J, K_JAL:   w_pc_exec = r_ir[PC_W-1:0];
      default:      w_pc_exec = w_pc_inc;
    endcase
  end

  // Registered outputs, loaded on the edge that enters the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir          <= 32'd0;
      r_pc          <= '0;
      r_rf_rs       <= 5'd0;
      r_rf_rt       <= 5'd0;
      r_rf_wr       <= 5'd0;
      r_rf_valid    <= 3'b000;
      r_alu_op      <= 2'd0;
      r_alu_src_imm <= 1'b0;
      r_imm         <= 8'd0;
      r_mem_rd      <= 1'b0;
      r_wb_sel      <= 2'd0;
      r_link_pc     <= '0;
      r_illegal     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_pc   <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
          end
        end
        S_FETCH: begin
          r_ir    <= inst;
          r_rf_rs <= inst[25:21];
          r_rf_rt <= inst[20:16];
          r_imm   <= inst[7:0];
          r_rf_wr <= wr_addr(inst, w_kind_in);
        end
        S_DECODE: r_rf_valid <= read_bits(w_kind);
        S_READ: begin
          r_rf_valid    <= 3'b000;
          r_alu_op      <= (w_kind == K_SUBU) ? 2'd1 : ((w_kind == K_SLT) ? 2'd2 : 2'd0);
          r_alu_src_imm <= (w_kind == K_ADDIU) || (w_kind == K_LW);
        end
        S_EXEC: begin
          r_pc     <= w_pc_exec;
          r_mem_rd <= (w_kind == K_LW);
          if (w_kind == K_JAL) r_link_pc <= w_pc_inc;
          if (w_kind == K_ILL) r_illegal <= 1'b1;
        end
        S_MEM: begin
          r_mem_rd   <= 1'b0;
          r_rf_valid <= (is_writer(w_kind) && (r_rf_wr != 5'd0)) ? 3'b001 : 3'b000;
          r_wb_sel   <= (w_kind == K_LW) ? 2'd1 : ((w_kind == K_JAL) ? 2'd2 : 2'd0);
        end
        S_WB: begin
          r_wb_sel <= 2'd0;
          if (w_halt) begin
            r_rf_rs    <= OUT_REG_L;
            r_rf_valid <= 3'b100;
          end else begin
            r_rf_valid <= 3'b000;
          end
        end
        S_DUMP: begin
          r_rf_valid <= 3'b000;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign rf_rs       = r_rf_rs;
  assign rf_rt       = r_rf_rt;
  assign rf_wr       = r_rf_wr;
  assign rf_valid    = r_rf_valid;
  assign alu_op      = r_alu_op;
  assign alu_src_imm = r_alu_src_imm;
  assign imm         = r_imm;
  assign mem_rd      = r_mem_rd;
  assign wb_sel      = r_wb_sel;
  assign link_pc     = r_link_pc;
  assign illegal     = r_illegal;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized scoreboard bench for mc_control_unit: an instruction-level model
// predicts each instruction's control trace; a monitor compares it phase by phase.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] inst;
  logic        alu_eq = 1'b0;
  logic [7:0]  rs_val = 8'd0;
  logic [7:0]  imem_addr;
  logic [4:0]  rf_rs, rf_rt, rf_wr;
  logic [2:0]  rf_valid;
  logic [1:0]  alu_op, wb_sel;
  logic        alu_src_imm, mem_rd, illegal, busy, done;
  logic [7:0]  imm, link_pc;

  mc_control_unit #(.PC_W(8), .MAX_PC(11), .OUTPUT_REG(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inst(inst), .alu_eq(alu_eq),
    .rs_val(rs_val), .imem_addr(imem_addr), .rf_rs(rf_rs), .rf_rt(rf_rt),
    .rf_wr(rf_wr), .rf_valid(rf_valid), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .imm(imm), .mem_rd(mem_rd), .wb_sel(wb_sel), .link_pc(link_pc),
    .illegal(illegal), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [1:0]  feq  [256];   // {force, value} for alu_eq at this PC
  assign inst = imem[imem_addr];

  typedef struct {
    logic [7:0] pc, npc, link, imm;
    logic [4:0] rs, rt, wr;
    logic [2:0] rdv, wbv;
    logic [1:0] aop, wsel;
    logic       asrc, chk_alu, chk_wr, is_jal, lw, ill, halt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  logic m_ill = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {13'd0, imem_addr, rf_rs, rf_rt, rf_wr, rf_valid, alu_op, alu_src_imm,
            imm, mem_rd, wb_sel, link_pc, illegal, busy, done};
  endfunction

  // Instruction-level reference: what one instruction should do, from the ISA rules.
  function automatic exp_t model(input logic [7:0] pc, input logic [31:0] w,
                                 input logic eq, input logic [7:0] rsv, input logic ill_in);
    exp_t e;
    logic [5:0] op, fn;
    logic addu, subu, slt, jr, addiu, lw, beq, bne, j, jal, legal, writer;
    int target;
    op = w[31:26]; fn = w[5:0];
    addu = (op == 6'h00) && (fn == 6'h21);
    subu = (op == 6'h00) && (fn == 6'h23);
    slt  = (op == 6'h00) && (fn == 6'h2A);
    jr   = (op == 6'h00) && (fn == 6'h08);
    addiu = (op == 6'h09); lw = (op == 6'h23); beq = (op == 6'h04);
    bne = (op == 6'h05); j = (op == 6'h02); jal = (op == 6'h03);
    legal  = addu | subu | slt | jr | addiu | lw | beq | bne | j | jal;
    writer = addu | subu | slt | addiu | lw | jal;
    e.pc = pc; e.rs = w[25:21]; e.rt = w[20:16]; e.imm = w[7:0];
    e.wr = (addu | subu | slt) ? w[15:11] : ((addiu | lw) ? w[20:16] : (jal ? 5'd31 : 5'd0));
    e.chk_wr = writer;
    e.rdv = (addu | subu | slt | jr | beq | bne) ? 3'b110 : ((addiu | lw) ? 3'b100 : 3'b000);
    e.chk_alu = addu | subu | slt | addiu | lw;
    e.aop = subu ? 2'd1 : (slt ? 2'd2 : 2'd0);
    e.asrc = addiu | lw;
    target = int'(pc) + 1;
    if (jr) target = int'(rsv);
    else if ((beq && eq) || (bne && !eq)) target = int'(pc) + int'($signed(w[7:0]));
    else if (j || jal) target = int'(w[7:0]);
    e.npc = 8'(target & 255);
    e.link = 8'((int'(pc) + 1) & 255);
    e.is_jal = jal; e.lw = lw;
    e.wbv = (writer && (e.wr != 5'd0)) ? 3'b001 : 3'b000;
    e.wsel = lw ? 2'd1 : (jal ? 2'd2 : 2'd0);
    e.ill = ill_in | ~legal;
    e.halt = (e.npc >= 8'd11);
    return e;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin imem[i] = 32'h0; feq[i] = 2'b00; end
  endtask

  // Forward-only random program so it always halts
  task automatic rand_prog();
    logic [31:0] r;
    logic [7:0]  offs [5];
    logic [7:0]  tgt;
    offs[0] = 8'd1; offs[1] = 8'd2; offs[2] = 8'd3; offs[3] = 8'd4; offs[4] = 8'hF4;
    clear_mem();
    for (int i = 0; i < 11; i++) begin
      r = $urandom;
      tgt = 8'($urandom_range(255, i + 1));
      case ($urandom_range(0, 10))
        0: imem[i] = {6'h00, r[25:11], 5'd0, 6'h21};
        1: imem[i] = {6'h00, r[25:11], 5'd0, 6'h23};
        2: imem[i] = {6'h00, r[25:11], 5'd0, 6'h2A};
        3: imem[i] = {6'h00, r[25:21], 15'd0, 6'h08};
        4: imem[i] = {6'h09, r[25:0]};
        5: imem[i] = {6'h23, r[25:0]};
        6: imem[i] = {6'h04, r[25:8], offs[$urandom_range(0, 4)]};
        7: imem[i] = {6'h05, r[25:8], offs[$urandom_range(0, 4)]};
        8: imem[i] = {6'h02, r[25:8], tgt};
        9: imem[i] = {6'h03, r[25:8], tgt};
        default: imem[i] = r[0] ? {6'h3F, r[25:0]} : {6'h00, r[25:6], 6'h00};
      endcase
    end
  endtask

  // Issue start, then feed per-instruction alu_eq/rs_val and push expectations
  task automatic run_prog();
    logic [7:0] pc;
    logic       eq;
    logic [7:0] rsv;
    exp_t       e;
    int         n;
    pc = 8'd0; n = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    do begin
      eq  = feq[pc][1] ? feq[pc][0] : 1'($urandom_range(0, 1));
      rsv = 8'($urandom_range(255, int'(pc) + 1));
      alu_eq = eq; rs_val = rsv;
      e = model(pc, imem[pc], eq, rsv, m_ill);
      m_ill = e.ill;
      q.push_back(e);
      repeat (6) @(posedge clk);
      #1;
      pc = e.npc; n++;
    end while (!e.halt && n < 64);
    @(posedge clk); #1;
  endtask

  // Monitor: one expected record per instruction, checked across its six phases
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && busy) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_instr: got busy=1 with no expected instruction at %0t", $time);
          continue;
        end
        e = q.pop_front();
        chk("fetch_pc", imem_addr, e.pc);
        chk("fetch_valid", rf_valid, 3'b000);
        chk("fetch_busy_done", {busy, done}, 2'b10);
        @(negedge clk);
        chk("dec_rs", rf_rs, e.rs);
        chk("dec_rt", rf_rt, e.rt);
        chk("dec_imm", imm, e.imm);
        if (e.chk_wr) chk("dec_wr", rf_wr, e.wr);
        @(negedge clk);
        chk("read_valid", rf_valid, e.rdv);
        @(negedge clk);
        chk("exec_valid", rf_valid, 3'b000);
        chk("exec_memrd", mem_rd, 1'b0);
        if (e.chk_alu) chk("exec_alu", {alu_op, alu_src_imm}, {e.aop, e.asrc});
        @(negedge clk);
        chk("mem_memrd", mem_rd, e.lw);
        chk("mem_pc", imem_addr, e.npc);
        chk("mem_illegal", illegal, e.ill);
        if (e.is_jal) chk("mem_link", link_pc, e.link);
        @(negedge clk);
        chk("wb_valid", rf_valid, e.wbv);
        chk("wb_sel", wb_sel, e.wsel);
        chk("wb_memrd", mem_rd, 1'b0);
        if (e.chk_wr) chk("wb_wr", rf_wr, e.wr);
        if (e.halt) begin
          @(negedge clk);
          chk("dump_rs_valid", {rf_rs, rf_valid}, {5'd4, 3'b100});
          chk("dump_busy_done", {busy, done}, 2'b10);
          @(negedge clk);
          chk("done_state", {busy, done, rf_valid}, {2'b01, 3'b000});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    clear_mem();
    repeat (2) @(posedge clk);
    #1 chk("por_outputs", all_outs(), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;

    // Straight-line ops, illegal opcode, j, bne back-edge, beq to halt
    clear_mem();
    imem[0] = 32'h24040000; imem[1] = 32'h8C010000; imem[2] = 32'h24200005;
    imem[3] = 32'hFC000000; imem[4] = 32'h0022282A; imem[5] = 32'h00223023;
    imem[6] = 32'h0800000A; imem[10] = 32'h14C0FFFD; feq[10] = 2'b10;
    imem[7] = 32'h10C00004; feq[7] = 2'b11;
    run_prog();

    // Restart from DONE: illegal must stay set; jal out of range halts
    clear_mem();
    imem[0] = 32'h24040000; imem[1] = 32'h24200005; imem[2] = 32'h00221821;
    imem[3] = 32'h0C000020;
    run_prog();

    clear_mem();
    imem[0] = 32'h08000006; imem[6] = 32'h10C00005; feq[6] = 2'b11;
    run_prog();

    for (int p = 0; p < 8; p++) begin
      rand_prog();
      run_prog();
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    // Asynchronous reset in the middle of EXEC
    mon_en = 1'b0;
    clear_mem();
    imem[0] = 32'h00221821;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("exec_before_reset", {busy, rf_rs, rf_rt}, {1'b1, 5'd1, 5'd2});
    rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    m_ill = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("restart_fetch", {imem_addr, busy, done, illegal}, {8'd0, 1'b1, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
